// File: rtl/multicycle_maindec.sv
// rtl/multicycle_maindec.sv - main control FSM for the multicycle MIPS datapath
//
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives the datapath strobes and mux selects as a Moore decode of state.
//
// Parameters:
//   SUPPORT_BNE  - opcode 000101 is legal (else reported as illegal)
//   SUPPORT_ADDI - opcode 001000 is legal (else reported as illegal)
//   MEM_WAIT     - memory states wait for mem_ready (else mem_ready ignored)
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   op [5:0]              - opcode from the instruction register
//   mem_ready             - memory completed the current access this cycle
//   mem_req               - memory access request
//   pcwrite, irwrite, regwrite, memwrite - write strobes
//   iord, alusrca, memtoreg, regdst      - mux selects
//   branch, branchne      - BEQ / BNE branch enables
//   alusrcb, pcsrc, aluop - 2-bit selects / ALU operation class
//   illegal_op            - unsupported opcode seen in DECODE
//   state [3:0]           - current state, for debug
module multicycle_maindec #(
    parameter bit SUPPORT_BNE  = 1'b1,
    parameter bit SUPPORT_ADDI = 1'b1,
    parameter bit MEM_WAIT     = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       memtoreg,
    output logic       regdst,
    output logic       branch,
    output logic       branchne,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    state_t cur, nxt, dec_next;
    logic   op_legal;
    logic   rdy;
    // Remembers whether the branch being executed is BNE, so BRANCH does not
    // depend on op after DECODE.
    logic   is_bne;

    assign rdy   = mem_ready || !MEM_WAIT;
    assign state = cur;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur    <= S_FETCH;
            is_bne <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE) begin
                is_bne <= (op == OP_BNE);
            end
        end
    end

    // Opcode decode for the DECODE state
    always_comb begin
        dec_next = S_FETCH;
        op_legal = 1'b1;
        case (op)
            OP_LW, OP_SW: dec_next = S_MEMADR;
            OP_R:         dec_next = S_EXECUTE;
            OP_BEQ:       dec_next = S_BRANCH;
            OP_J:         dec_next = S_JUMP;
            OP_BNE: begin
                if (SUPPORT_BNE) dec_next = S_BRANCH;
                else             op_legal = 1'b0;
            end
            OP_ADDI: begin
                if (SUPPORT_ADDI) dec_next = S_ADDIEX;
                else              op_legal = 1'b0;
            end
            default:      op_legal = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:   nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE:  nxt = dec_next;
            S_MEMADR:  nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   nxt = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:   nxt = rdy ? S_FETCH : S_MEMWR;
            S_EXECUTE: nxt = S_ALUWB;
            S_ADDIEX:  nxt = S_ADDIWB;
            default:   nxt = S_FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        mem_req    = 1'b0;
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        branch     = 1'b0;
        branchne   = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = rdy;
                pcwrite = rdy;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = !op_legal;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsrc    = 2'b01;
                branch   = !is_bne;
                branchne = is_bne;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        // Strobes are suppressed combinationally for the whole reset window.
        if (!reset_n) begin
            mem_req    = 1'b0;
            pcwrite    = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            memwrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_maindec.sv
// tb/tb_multicycle_maindec.sv - scoreboard bench for multicycle_maindec
module tb_multicycle_maindec;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    logic clk = 1'b0;
    logic rst1_n, rst2_n, mem_ready;
    logic [5:0] op;

    logic mem_req1, pcwrite1, irwrite1, regwrite1, memwrite1, iord1, alusrca1;
    logic memtoreg1, regdst1, branch1, branchne1, illegal_op1;
    logic [1:0] alusrcb1, pcsrc1, aluop1;
    logic [3:0] state1;
    logic mem_req2, pcwrite2, irwrite2, regwrite2, memwrite2, iord2, alusrca2;
    logic memtoreg2, regdst2, branch2, branchne2, illegal_op2;
    logic [1:0] alusrcb2, pcsrc2, aluop2;
    logic [3:0] state2;

    always #5 clk = ~clk;

    multicycle_maindec dut1 (
        .clk(clk), .reset_n(rst1_n), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req1), .pcwrite(pcwrite1), .irwrite(irwrite1),
        .regwrite(regwrite1), .memwrite(memwrite1), .iord(iord1),
        .alusrca(alusrca1), .memtoreg(memtoreg1), .regdst(regdst1),
        .branch(branch1), .branchne(branchne1), .alusrcb(alusrcb1),
        .pcsrc(pcsrc1), .aluop(aluop1), .illegal_op(illegal_op1), .state(state1)
    );

    multicycle_maindec #(.SUPPORT_BNE(1'b0), .SUPPORT_ADDI(1'b0), .MEM_WAIT(1'b0)) dut2 (
        .clk(clk), .reset_n(rst2_n), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req2), .pcwrite(pcwrite2), .irwrite(irwrite2),
        .regwrite(regwrite2), .memwrite(memwrite2), .iord(iord2),
        .alusrca(alusrca2), .memtoreg(memtoreg2), .regdst(regdst2),
        .branch(branch2), .branchne(branchne2), .alusrcb(alusrcb2),
        .pcsrc(pcsrc2), .aluop(aluop2), .illegal_op(illegal_op2), .state(state2)
    );

    // Observed vector: {state, mem_req, pcwrite, irwrite, regwrite, memwrite, iord,
    // alusrca, memtoreg, regdst, branch, branchne, alusrcb, pcsrc, aluop, illegal_op}
    logic [21:0] obs1, obs2;
    assign obs1 = {state1, mem_req1, pcwrite1, irwrite1, regwrite1, memwrite1, iord1,
                   alusrca1, memtoreg1, regdst1, branch1, branchne1, alusrcb1,
                   pcsrc1, aluop1, illegal_op1};
    assign obs2 = {state2, mem_req2, pcwrite2, irwrite2, regwrite2, memwrite2, iord2,
                   alusrca2, memtoreg2, regdst2, branch2, branchne2, alusrcb2,
                   pcsrc2, aluop2, illegal_op2};

    typedef struct {
        bit          sel;
        logic [21:0] exp;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   tag_cnt = 0;

    // Configuration of the instance currently under stimulus
    bit cur_sel, p_bne, p_addi, p_mw;

    // Spec output table per state; the instruction-level sequencing lives in run_instr.
    function automatic logic [17:0] state_outputs(input int st, input bit rdy,
                                                  input bit bne, input bit ill);
        bit mreq = 0, pcw = 0, irw = 0, rw = 0, mw = 0, iord = 0, asa = 0;
        bit m2r = 0, rdst = 0, br = 0, brn = 0, illo = 0;
        bit [1:0] asb = 0, pcs = 0, aop = 0;
        case (st)
            0:  begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin asb = 2'b11; illo = ill; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mreq = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mreq = 1; iord = 1; mw = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = !bne; brn = bne; end
            9:  begin asa = 1; asb = 2'b10; end
            10: begin rw = 1; end
            11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {mreq, pcw, irw, rw, mw, iord, asa, m2r, rdst, br, brn, asb, pcs, aop, illo};
    endfunction

    // Drive one cycle of inputs and push the expected response of that cycle.
    task automatic issue(input int st, input bit mr, input logic [5:0] o,
                         input bit ill, input bit bne, input bit rst);
        exp_t e;
        logic [17:0] v;
        mem_ready = mr;
        op        = o;
        rst1_n    = (cur_sel == 1'b0) ? !rst : 1'b0;
        rst2_n    = (cur_sel == 1'b1) ? !rst : 1'b0;
        v = state_outputs(st, mr | !p_mw, bne, ill);
        if (rst) v = v & 18'b000001111111111110;
        e.sel = cur_sel;
        e.exp = {4'(st), v};
        e.tag = tag_cnt;
        tag_cnt++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Waitable memory-facing state: 'waits' cycles of mem_ready=0, then ready.
    task automatic wait_state(input int st, input int waits, input logic [5:0] o);
        int w = waits;
        bit mr;
        do begin
            mr = (w > 0) ? 1'b0 : 1'b1;
            w--;
            issue(st, mr, (st == 2) ? o : 6'($urandom), 0, 0, 0);
        end while (!(mr | !p_mw));
    endtask

    task automatic run_instr(input logic [5:0] o, input int fw, input int mw);
        bit legal;
        wait_state(0, fw, o);
        legal = (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_BEQ) ||
                (o == OP_J) || (o == OP_BNE && p_bne) || (o == OP_ADDI && p_addi);
        issue(1, 1'($urandom), o, !legal, 0, 0);
        if (legal) begin
            case (o)
                OP_LW:   begin issue(2, 1'($urandom), o, 0, 0, 0); wait_state(3, mw, o);
                               issue(4, 1'($urandom), 6'($urandom), 0, 0, 0); end
                OP_SW:   begin issue(2, 1'($urandom), o, 0, 0, 0); wait_state(5, mw, o); end
                OP_R:    begin issue(6, 1'($urandom), 6'($urandom), 0, 0, 0);
                               issue(7, 1'($urandom), 6'($urandom), 0, 0, 0); end
                OP_BEQ:  issue(8, 1'($urandom), 6'($urandom), 0, 0, 0);
                OP_BNE:  issue(8, 1'($urandom), 6'($urandom), 0, 1, 0);
                OP_ADDI: begin issue(9, 1'($urandom), 6'($urandom), 0, 0, 0);
                               issue(10, 1'($urandom), 6'($urandom), 0, 0, 0); end
                default: issue(11, 1'($urandom), 6'($urandom), 0, 0, 0);
            endcase
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [8];
        tbl = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_J, 6'b000000};
        tbl[7] = 6'($urandom);
        return tbl[$urandom_range(0, 7)];
    endfunction

    // Monitor: compare every cycle for which an expectation is queued
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [21:0] got;
            e = exp_q.pop_front();
            got = e.sel ? obs2 : obs1;
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL cycle%0d dut%0d state/outputs: got %h expected %h",
                         e.tag, e.sel + 1, got, e.exp);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst1_n = 0; rst2_n = 0; mem_ready = 0; op = 0;
        cur_sel = 0; p_bne = 1; p_addi = 1; p_mw = 1;
        repeat (2) @(posedge clk);
        #1;

        // Phase 1: default configuration
        issue(0, 0, 6'($urandom), 0, 0, 1);
        issue(0, 1, 6'($urandom), 0, 0, 1);
        // Reset in the middle of a stalled SW write
        issue(0, 1, OP_SW, 0, 0, 0);
        issue(1, 1, OP_SW, 0, 0, 0);
        issue(2, 1, OP_SW, 0, 0, 0);
        issue(5, 0, 6'($urandom), 0, 0, 0);
        issue(5, 0, 6'($urandom), 0, 0, 1);
        issue(0, 0, 6'($urandom), 0, 0, 1);
        run_instr(OP_LW, 0, 0);
        run_instr(OP_SW, 0, 3);
        run_instr(OP_LW, 2, 1);
        run_instr(OP_BNE, 0, 0);
        run_instr(OP_BEQ, 1, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(OP_R, 0, 0);
        run_instr(6'b111111, 0, 0);
        for (int i = 0; i < 60; i++) begin
            run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Phase 2: BNE/ADDI disabled, memory wait ignored
        cur_sel = 1; p_bne = 0; p_addi = 0; p_mw = 0;
        issue(0, 0, 6'($urandom), 0, 0, 1);
        run_instr(OP_BNE, 2, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(OP_LW, 3, 3);
        run_instr(OP_SW, 1, 2);
        for (int i = 0; i < 40; i++) begin
            run_instr(pick_op(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
